// File: rtl/mips_mmio_pkg.sv
// Shared constants for the MEM-stage MMIO port bridge: default window base,
// register word indices and STATUS bit positions.
package mips_mmio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

   localparam logic [1:0] REG_PORT_OUT = 2'd0;
   localparam logic [1:0] REG_PORT_IN  = 2'd1;
   localparam logic [1:0] REG_STATUS   = 2'd2;
   localparam logic [1:0] REG_IRQ_EN   = 2'd3;

   localparam int STATUS_CHG_BIT = 0;

   function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:4] == base[31:4];
   endfunction

endpackage

// File: rtl/mmio_port_bridge_if.sv
// MEM-stage load/store bus between the pipeline (master) and the MMIO bridge (slave).
interface mmio_port_bridge_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic        IoSel;
   logic [31:0] ReadData;

   modport master (output Address, output WriteData, output MemWrite, output MemRead,
                   input  IoSel,   input  ReadData);
   modport slave  (input  Address, input  WriteData, input  MemWrite, input  MemRead,
                   output IoSel,   output ReadData);
endinterface

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for an asynchronous bus; synchronous active-high reset.
module input_synchronizer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
      end
   end

   assign o_sync = r_sync2;

endmodule

// File: rtl/mmio_port_bridge.sv
// 16-byte MMIO window beside data memory: PORT_OUT, synchronized PORT_IN, sticky CHG.
// Optional IRQ_EN register and Irq output are built when MMIO_IRQ_EN is defined.
module mmio_port_bridge
   import mips_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          IN_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                reset,
   mmio_port_bridge_if.slave   bus,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         PortOut,
   output logic                Irq
);

   logic [IN_WIDTH-1:0] w_sync2;
   logic [IN_WIDTH-1:0] r_prev;
   logic [31:0]         r_port_out;
   logic                r_chg;
   logic                w_hit;
   logic [1:0]          w_idx;
   logic                w_wr;
   logic                w_chg_set;
   logic                w_chg_clr;
   logic                w_irq_en;
   logic [31:0]         w_rdata;

   input_synchronizer #(.WIDTH(IN_WIDTH)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (PortIn),
      .o_sync  (w_sync2)
   );

   assign w_hit     = addr_hit(bus.Address, BASE_ADDR);
   assign w_idx     = bus.Address[3:2];
   assign w_wr      = w_hit & bus.MemWrite;
   assign w_chg_set = (w_sync2 != r_prev);
   assign w_chg_clr = w_wr & (w_idx == REG_STATUS) & bus.WriteData[STATUS_CHG_BIT];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_port_out <= '0;
         r_prev     <= '0;
         r_chg      <= 1'b0;
      end else begin
         r_prev <= w_sync2;
         if (w_wr && (w_idx == REG_PORT_OUT))
            r_port_out <= bus.WriteData;
         // a fresh change outranks a simultaneous W1C so no edge is lost
         if (w_chg_set)
            r_chg <= 1'b1;
         else if (w_chg_clr)
            r_chg <= 1'b0;
      end
   end

`ifdef MMIO_IRQ_EN
   logic r_irq_en;

   always_ff @(posedge clk) begin
      if (reset)
         r_irq_en <= 1'b0;
      else if (w_wr && (w_idx == REG_IRQ_EN))
         r_irq_en <= bus.WriteData[0];
   end

   assign w_irq_en = r_irq_en;
`else
   assign w_irq_en = 1'b0;
`endif

   always_comb begin
      w_rdata = 32'h0;
      unique case (w_idx)
         REG_PORT_OUT: w_rdata = r_port_out;
         REG_PORT_IN:  w_rdata = 32'(w_sync2);
         REG_STATUS:   w_rdata[STATUS_CHG_BIT] = r_chg;
         REG_IRQ_EN:   w_rdata[0] = w_irq_en;
         default:      w_rdata = 32'h0;
      endcase
   end

   assign bus.IoSel    = w_hit;
   assign bus.ReadData = (w_hit & bus.MemRead) ? w_rdata : 32'h0;
   assign PortOut      = r_port_out;
   assign Irq          = r_chg & w_irq_en;

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Directed bench for mmio_port_bridge; expectations follow MMIO_IRQ_EN when defined.
module tb_mmio_port_bridge;

   logic        clk;
   logic        reset;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic        Irq;
   logic [31:0] rd;
   int          total;
   int          bad;

`ifdef MMIO_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   mmio_port_bridge_if bus ();

   mmio_port_bridge #(.BASE_ADDR(32'hFFFF_0000), .IN_WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .PortIn  (PortIn),
      .PortOut (PortOut),
      .Irq     (Irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // caller is at a negedge; the store lands on the following posedge
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.Address   = a;
      bus.WriteData = d;
      bus.MemWrite  = 1'b1;
      @(negedge clk);
      bus.MemWrite  = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, output logic [31:0] d);
      bus.Address = a;
      bus.MemRead = 1'b1;
      #1;
      d = bus.ReadData;
      bus.MemRead = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      PortIn = 8'h00;
      bus.Address = 32'h0; bus.WriteData = 32'h0;
      bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_portout", PortOut, 32'h0);
      chk("rst_irq", {31'h0, Irq}, 32'h0);
      load(32'hFFFF_0008, rd); chk("rst_status", rd, 32'h0);
      load(32'hFFFF_0000, rd); chk("rst_rd_out", rd, 32'h0);

      bus.Address = 32'hFFFF_0000; bus.WriteData = 32'hDEADBEEF; bus.MemWrite = 1'b1;
      #1 chk("iosel_hit", {31'h0, bus.IoSel}, 32'h1);
      @(negedge clk); bus.MemWrite = 1'b0;
      chk("portout_wr", PortOut, 32'hDEADBEEF);

      bus.Address = 32'h1001_0000; bus.WriteData = 32'h0000_0055; bus.MemWrite = 1'b1;
      #1 chk("iosel_miss", {31'h0, bus.IoSel}, 32'h0);
      @(negedge clk); bus.MemWrite = 1'b0;
      chk("portout_keep", PortOut, 32'hDEADBEEF);
      load(32'h1001_0000, rd); chk("rd_miss_zero", rd, 32'h0);
      load(32'hFFFF_0000, rd); chk("rd_portout", rd, 32'hDEADBEEF);

      // PortIn change ahead of edge N
      PortIn = 8'hA5;
      @(negedge clk);
      load(32'hFFFF_0004, rd); chk("in_after_n", rd, 32'h0);
      @(negedge clk);
      load(32'hFFFF_0004, rd); chk("in_after_n1", rd, 32'h0000_00A5);
      load(32'hFFFF_0008, rd); chk("chg_after_n1", rd, 32'h0);
      @(negedge clk);
      load(32'hFFFF_0008, rd); chk("chg_after_n2", rd, 32'h1);

      store(32'hFFFF_0008, 32'h0);
      load(32'hFFFF_0008, rd); chk("w0c_noeffect", rd, 32'h1);
      store(32'hFFFF_0008, 32'h1);
      load(32'hFFFF_0008, rd); chk("w1c_clear", rd, 32'h0);

      // W1C lands on the same edge that sets CHG
      PortIn = 8'h5A;
      @(negedge clk); @(negedge clk);
      store(32'hFFFF_0008, 32'h1);
      load(32'hFFFF_0008, rd); chk("set_beats_clr", rd, 32'h1);
      store(32'hFFFF_0008, 32'h1);
      load(32'hFFFF_0008, rd); chk("w1c_clear2", rd, 32'h0);

      store(32'hFFFF_0004, 32'hFFFF_FFFF);
      load(32'hFFFF_0004, rd); chk("portin_ro", rd, 32'h0000_005A);

      bus.Address = 32'hFFFF_0000; bus.WriteData = 32'h1122_3344;
      bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
      #1 chk("rw_prewrite", bus.ReadData, 32'hDEADBEEF);
      @(negedge clk); bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
      chk("rw_written", PortOut, 32'h1122_3344);
      load(32'hFFFF_0003, rd); chk("low_bits_ign", rd, 32'h1122_3344);

      store(32'hFFFF_000C, 32'h1);
      load(32'hFFFF_000C, rd); chk("irq_en_rd", rd, {31'h0, IRQ_ON});
      PortIn = 8'h00;
      @(negedge clk); @(negedge clk);
      chk("irq_n1", {31'h0, Irq}, 32'h0);
      @(negedge clk);
      chk("irq_n2", {31'h0, Irq}, {31'h0, IRQ_ON});
      store(32'hFFFF_0008, 32'h1);
      chk("irq_w1c", {31'h0, Irq}, 32'h0);

      bus.Address = 32'hFFFF_0000; bus.WriteData = 32'h0000_1234; bus.MemWrite = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; bus.MemWrite = 1'b0;
      chk("rst_beats_wr", PortOut, 32'h0);
      load(32'hFFFF_000C, rd); chk("rst_irq_en", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
